// File: rtl/debounce_sync_if.sv
// Pin-conditioning bundle: raw pin levels in, clean levels, edge pulses and
// the startup-qualified flag out.
interface debounce_sync_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             VALID;

  // Levels only, no handshake: I is sampled on every CLK edge, and every
  // output is a registered level (RISE/FALL are single-cycle strobes).
  modport master (output I, input O, RISE, FALL, VALID);
  modport slave  (input I, output O, RISE, FALL, VALID);
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser and per-bit stability-counter debouncer. Edge pulses
// are suppressed until the startup qualification window has elapsed.
module debounce_sync #(
  parameter int WIDTH        = 4,
  parameter int CNT_BITS     = 14,
  parameter int STABLE_COUNT = 12000
) (
  input  logic            CLK,
  input  logic            RESETN,
  debounce_sync_if.slave  bus
);

  localparam int START_BITS = $clog2(STABLE_COUNT + 3);
  localparam logic [CNT_BITS-1:0]   CNT_LAST   = CNT_BITS'(STABLE_COUNT - 1);
  localparam logic [START_BITS-1:0] START_LAST = START_BITS'(STABLE_COUNT + 1);

  logic [WIDTH-1:0]      s1;
  logic [WIDTH-1:0]      s2;
  logic [WIDTH-1:0]      o_q;
  logic [WIDTH-1:0]      o_next;
  logic [WIDTH-1:0]      rise_q;
  logic [WIDTH-1:0]      fall_q;
  logic [CNT_BITS-1:0]   cnt      [WIDTH];
  logic [CNT_BITS-1:0]   cnt_next [WIDTH];
  logic [START_BITS-1:0] start_cnt;
  logic                  valid_q;

  // Only s2 feeds the debounce decision; s1 may be metastable.
  always_comb begin
    o_next   = o_q;
    cnt_next = cnt;
    for (int b = 0; b < WIDTH; b++) begin
      if (s2[b] == o_q[b]) begin
        cnt_next[b] = '0;
      end else if (cnt[b] == CNT_LAST) begin
        o_next[b]   = s2[b];
        cnt_next[b] = '0;
      end else begin
        cnt_next[b] = cnt[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1        <= '0;
      s2        <= '0;
      o_q       <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      cnt       <= '{default: '0};
      start_cnt <= '0;
      valid_q   <= 1'b0;
    end else begin
      s1     <= bus.I;
      s2     <= s1;
      o_q    <= o_next;
      cnt    <= cnt_next;
      // Old valid_q gates the pulses, so an edge landing on the qualifying cycle stays silent.
      rise_q <= valid_q ? (o_next & ~o_q) : '0;
      fall_q <= valid_q ? (~o_next & o_q) : '0;
      if (!valid_q) begin
        start_cnt <= start_cnt + 1'b1;
        if (start_cnt == START_LAST) begin
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.O     = o_q;
  assign bus.RISE  = rise_q;
  assign bus.FALL  = fall_q;
  assign bus.VALID = valid_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: fixed vector table, hand-written corner sequences,
// then random pin activity against a sliding-window reference model.
module tb_debounce_sync;

  localparam int W  = 4;
  localparam int SC = 4;
  localparam int CB = 3;

  logic clk;
  logic rst_n;

  debounce_sync_if #(.WIDTH(W)) bus ();

  debounce_sync #(
    .WIDTH(W),
    .CNT_BITS(CB),
    .STABLE_COUNT(SC)
  ) dut (
    .CLK(clk),
    .RESETN(rst_n),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: O[b] flips once the last SC synchronised samples all differ from it.
  logic [W-1:0]     hist [0:SC];
  logic [W-1:0]     m_o;
  logic [W-1:0]     m_rise;
  logic [W-1:0]     m_fall;
  int               rel;
  logic [3*W:0]     exp_q [$];
  logic [3*W:0]     exp_last;

  task automatic model_reset();
    for (int k = 0; k <= SC; k++) hist[k] = '0;
    m_o    = '0;
    m_rise = '0;
    m_fall = '0;
    rel    = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] n_o;
    logic         pv;
    bit           flip;
    if (!rst_n) begin
      model_reset();
    end else begin
      pv  = (rel >= SC + 2);
      n_o = m_o;
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        for (int k = 1; k <= SC; k++) begin
          if (hist[k][b] == m_o[b]) flip = 1'b0;
        end
        if (flip) n_o[b] = ~m_o[b];
      end
      m_rise = pv ? (n_o & ~m_o) : '0;
      m_fall = pv ? (~n_o & m_o) : '0;
      for (int k = SC; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = bus.I;
      m_o = n_o;
      if (rel < SC + 2) rel++;
    end
    exp_q.push_back({(rel >= SC + 2), m_fall, m_rise, m_o});
  endtask

  // driver: one clock edge, model follows the same edge, return at negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_last = exp_q.pop_front();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_o"},     bus.O,           exp_last[W-1:0]);
    check({tag, "_rise"},  bus.RISE,        exp_last[2*W-1:W]);
    check({tag, "_fall"},  bus.FALL,        exp_last[3*W-1:2*W]);
    check({tag, "_valid"}, W'(bus.VALID),   W'(exp_last[3*W]));
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] i;
    logic [W-1:0] o;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         valid;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic rst, input logic [W-1:0] i, input logic [W-1:0] o,
                     input logic [W-1:0] r, input logic [W-1:0] f, input logic v, input int n);
    vec_t e;
    e.rst = rst; e.i = i; e.o = o; e.rise = r; e.fall = f; e.valid = v;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endtask

  int pulses;
  int r;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.I  = 4'hF;
    model_reset();

    // Table: reset with pins high, qualification window, full fall, clean rise on bit 0.
    add(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1);
    add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 5);
    add(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1);
    add(1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 5);
    add(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1);
    add(1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 5);
    add(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1, 1);
    add(1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 1);
    foreach (tbl[n]) begin
      rst_n = tbl[n].rst;
      bus.I = tbl[n].i;
      tick();
      check("tbl_o",     bus.O,            tbl[n].o);
      check("tbl_rise",  bus.RISE,         tbl[n].rise);
      check("tbl_fall",  bus.FALL,         tbl[n].fall);
      check("tbl_valid", W'(bus.VALID),    W'(tbl[n].valid));
    end

    // Glitch on bit 1: three cycles high, then back low.
    bus.I = 4'h3;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("glitch_o", bus.O, 4'h1);
    end
    bus.I = 4'h1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch_o", bus.O, 4'h1);
      check("glitch_rise", bus.RISE, 4'h0);
    end

    // Bounce on bit 2: 1,0,1,0 then hold 1.
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      bus.I = (k % 2 == 0) ? 4'h5 : 4'h1;
      tick();
      if (bus.RISE[2]) pulses++;
    end
    bus.I = 4'h5;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.RISE[2]) pulses++;
      if (k == 5) check("bounce_o_early", bus.O, 4'h1);
      if (k == 6) begin
        check("bounce_o", bus.O, 4'h5);
        check("bounce_rise", bus.RISE, 4'h4);
      end
    end
    check("bounce_pulses", W'(pulses), 4'd1);

    // Simultaneous rise on bits 1 and 3.
    bus.I = 4'h0;
    for (int k = 0; k < 8; k++) tick();
    check("simul_pre", bus.O, 4'h0);
    bus.I = 4'hA;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("simul_o_early", bus.O, 4'h0);
      if (k == 6) begin
        check("simul_o", bus.O, 4'hA);
        check("simul_rise", bus.RISE, 4'hA);
      end
      if (k == 7) check("simul_rise_clr", bus.RISE, 4'h0);
    end

    // Reset two cycles into a qualifying step.
    bus.I = 4'h5;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_o", bus.O, 4'h0);
    check("rst_valid", W'(bus.VALID), 4'h0);
    check("rst_rise", bus.RISE, 4'h0);
    check("rst_fall", bus.FALL, 4'h0);
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        check("rst_win_o", bus.O, 4'h0);
        check("rst_win_valid", W'(bus.VALID), 4'h0);
      end else begin
        check("rst_rel_o", bus.O, 4'h5);
        check("rst_rel_valid", W'(bus.VALID), 4'h1);
        check("rst_rel_rise", bus.RISE, 4'h0);
      end
    end

    // Random pin activity with occasional resets, scored against the model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 199);
      if (r == 0) rst_n = 1'b0;
      else if (!rst_n && r < 100) rst_n = 1'b1;
      if ($urandom_range(0, 9) == 0) bus.I = bus.I ^ W'($urandom_range(1, 15));
      tick();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
